// File: rtl/postmortem_capture_ctrl.sv
// Write-side controller for the postmortem ring buffer: streams samples into the
// RAM write port as a ring, records a fixed post-trigger tail, then freezes.
module postmortem_capture_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int RAM_DEPTH  = 50000,
  parameter int POST_DEPTH = 25000,
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int VW = $clog2(RAM_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic              i_sample_valid,
  input  logic [DWIDTH-1:0] i_sample,
  input  logic              i_trig,
  output logic [AW-1:0]     o_ram_addr,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [DWIDTH-1:0] o_ram_din,
  output logic [1:0]        o_state,
  output logic              o_done,
  output logic [AW-1:0]     o_trig_addr,
  output logic [AW-1:0]     o_start_addr,
  output logic [VW-1:0]     o_valid_cnt
);

  localparam int PW = $clog2(POST_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [VW-1:0] FULL_CNT  = VW'(RAM_DEPTH);
  localparam logic [PW-1:0] LAST_POST = PW'(POST_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     trig_addr;
  logic [AW-1:0]     ram_addr;
  logic [VW-1:0]     valid_cnt;
  logic [PW-1:0]     post_cnt;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_wr;
  logic              done;
  logic              accept;

  assign accept = i_sample_valid && (state == RUN || state == POST);

  // Ring write path and capture FSM share one register block; the write
  // port is driven one cycle after the sample is accepted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      trig_addr <= '0;
      ram_addr  <= '0;
      valid_cnt <= '0;
      post_cnt  <= '0;
      ram_din   <= '0;
      ram_wr    <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_wr <= accept;
      if (accept) begin
        ram_addr <= wr_ptr;
        ram_din  <= i_sample;
        wr_ptr   <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
        if (valid_cnt != FULL_CNT)
          valid_cnt <= valid_cnt + VW'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (i_arm) begin
            state     <= RUN;
            done      <= 1'b0;
            wr_ptr    <= '0;
            valid_cnt <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
          end
        end
        RUN: begin
          if (i_trig) begin
            trig_addr <= wr_ptr;
            if (i_sample_valid) begin
              // The trigger-cycle sample is the first post-trigger sample.
              post_cnt <= PW'(1);
              if (POST_DEPTH == 1) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (i_sample_valid) begin
            post_cnt <= post_cnt + PW'(1);
            if (post_cnt == LAST_POST) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ram_addr   = ram_addr;
  assign o_ram_din    = ram_din;
  assign o_ram_ce     = ram_wr;
  assign o_ram_we     = ram_wr;
  assign o_state      = state;
  assign o_done       = done;
  assign o_trig_addr  = trig_addr;
  assign o_valid_cnt  = valid_cnt;
  // Once the ring has wrapped, the oldest word sits where the next write would go.
  assign o_start_addr = (state == DONE && valid_cnt == FULL_CNT) ? wr_ptr : '0;

endmodule

// File: tb/tb_postmortem_capture_ctrl.sv
// Bench for postmortem_capture_ctrl: vector table, directed corner sequences and
// random traffic against a sample-count model of the ring and a RAM model.
module tb_postmortem_capture_ctrl;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int P  = 3;
  localparam int AW = 3;
  localparam int VW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_arm = 1'b0;
  logic          i_sample_valid = 1'b0;
  logic [DW-1:0] i_sample = '0;
  logic          i_trig = 1'b0;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_ce;
  logic          o_ram_we;
  logic [DW-1:0] o_ram_din;
  logic [1:0]    o_state;
  logic          o_done;
  logic [AW-1:0] o_trig_addr;
  logic [AW-1:0] o_start_addr;
  logic [VW-1:0] o_valid_cnt;

  postmortem_capture_ctrl #(.DWIDTH(DW), .RAM_DEPTH(D), .POST_DEPTH(P)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_arm(i_arm), .i_sample_valid(i_sample_valid),
    .i_sample(i_sample), .i_trig(i_trig), .o_ram_addr(o_ram_addr), .o_ram_ce(o_ram_ce),
    .o_ram_we(o_ram_we), .o_ram_din(o_ram_din), .o_state(o_state), .o_done(o_done),
    .o_trig_addr(o_trig_addr), .o_start_addr(o_start_addr), .o_valid_cnt(o_valid_cnt)
  );

  always #5 i_clk = ~i_clk;

  // RAM as seen through the DUT's write port
  logic [DW-1:0] dut_ram [D];
  always @(posedge i_clk) if (o_ram_ce && o_ram_we) dut_ram[o_ram_addr] <= o_ram_din;

  int total = 0;
  int bad = 0;

  // Model: count of samples since arm and the count at trigger time
  int            m_phase = 0;
  int            m_n = 0;
  int            m_trig_n = 0;
  logic          m_pend = 1'b0;
  int            m_paddr = 0;
  logic [DW-1:0] m_pdin = '0;
  logic [DW-1:0] ram_exp [D];

  typedef struct {
    logic          arm;
    logic          valid;
    logic [DW-1:0] sample;
    logic          trig;
    logic [1:0]    st;
    logic          ce;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          done;
    logic [AW-1:0] taddr;
    logic [VW-1:0] vc;
    logic [AW-1:0] saddr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_n = 0;
    m_trig_n = 0;
    m_pend = 1'b0;
  endtask

  task automatic model_step(input logic arm, input logic valid, input logic [DW-1:0] sample,
                            input logic trig);
    if (m_pend) ram_exp[m_paddr] = m_pdin;
    m_pend = 1'b0;
    if (m_phase == 0 || m_phase == 3) begin
      if (arm) begin
        m_phase = 1;
        m_n = 0;
        m_trig_n = 0;
      end
    end else begin
      if (m_phase == 1 && trig) begin
        m_phase = 2;
        m_trig_n = m_n;
      end
      if (valid) begin
        m_pend = 1'b1;
        m_paddr = m_n % D;
        m_pdin = sample;
        m_n++;
      end
      if (m_phase == 2 && m_n - m_trig_n >= P) m_phase = 3;
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic apply_stimulus(input logic arm, input logic valid, input logic [DW-1:0] sample,
                                input logic trig);
    i_arm = arm;
    i_sample_valid = valid;
    i_sample = sample;
    i_trig = trig;
    model_step(arm, valid, sample, trig);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic check_output();
    chk("state", o_state, m_phase);
    chk("done", o_done, m_phase == 3);
    chk("ram_ce", o_ram_ce, m_pend);
    chk("ram_we", o_ram_we, m_pend);
    if (m_pend) begin
      chk("ram_addr", o_ram_addr, m_paddr);
      chk("ram_din", o_ram_din, m_pdin);
    end
    chk("trig_addr", o_trig_addr, m_trig_n % D);
    chk("valid_cnt", o_valid_cnt, (m_n < D) ? m_n : D);
    chk("start_addr", o_start_addr, (m_phase == 3 && m_n >= D) ? m_n % D : 0);
  endtask

  task automatic step(input logic arm, input logic valid, input logic [DW-1:0] sample,
                      input logic trig);
    apply_stimulus(arm, valid, sample, trig);
    check_output();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, o_ram_addr, 0);
    chk({tag, "_ce"}, o_ram_ce, 0);
    chk({tag, "_we"}, o_ram_we, 0);
    chk({tag, "_din"}, o_ram_din, 0);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_taddr"}, o_trig_addr, 0);
    chk({tag, "_saddr"}, o_start_addr, 0);
    chk({tag, "_vcnt"}, o_valid_cnt, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, away from any clock edge
  task automatic do_reset(input string tag);
    #2;
    i_rst = 1'b0;
    i_arm = 1'b0;
    i_sample_valid = 1'b0;
    i_trig = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    check_zero(tag);
    i_rst = 1'b1;
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < D; i++) chk($sformatf("%s_ram%0d", tag, i), dut_ram[i], ram_exp[i]);
  endtask

  function automatic vec_t mk(input logic arm, input logic valid, input int sample, input logic trig,
                              input int st, input logic ce, input int addr, input int din,
                              input logic done, input int taddr, input int vc, input int saddr);
    vec_t v;
    v.arm = arm; v.valid = valid; v.sample = DW'(sample); v.trig = trig;
    v.st = 2'(st); v.ce = ce; v.addr = AW'(addr); v.din = DW'(din);
    v.done = done; v.taddr = AW'(taddr); v.vc = VW'(vc); v.saddr = AW'(saddr);
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_wrap [D];
    exp_wrap = '{9, 10, 11, 12, 13, 6, 7, 8};

    // Reset asserted from time 0, samples offered while held
    i_sample_valid = 1'b1;
    i_sample = 32'hdead;
    @(negedge i_clk);
    check_zero("por");
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(100 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(200 + i), 1'b0);
    do_reset("rst_run");
    step(1'b0, 1'b0, '0, 1'b0);

    // Arm together with trigger in IDLE: arm only
    step(1'b1, 1'b0, '0, 1'b1);
    chk("arm_trig_state", o_state, 1);
    step(1'b0, 1'b0, '0, 1'b0);
    do_reset("rst_pre_tbl");

    // Trigger-with-sample vector table
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0, 1, k, 0, 1, 1, k - 1, k, 0, 0, k, 0));
    tbl.push_back(mk(0, 1, 6, 1, 2, 1, 5, 6, 0, 5, 6, 0));
    tbl.push_back(mk(0, 1, 7, 0, 2, 1, 6, 7, 0, 5, 7, 0));
    tbl.push_back(mk(0, 1, 8, 0, 3, 1, 7, 8, 1, 5, 8, 0));
    tbl.push_back(mk(0, 1, 9, 0, 3, 0, 0, 0, 1, 5, 8, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 1, 5, 8, 0));
    for (int r = 0; r < tbl.size(); r++) begin
      apply_stimulus(tbl[r].arm, tbl[r].valid, tbl[r].sample, tbl[r].trig);
      chk($sformatf("tbl%0d_state", r), o_state, tbl[r].st);
      chk($sformatf("tbl%0d_ce", r), o_ram_ce, tbl[r].ce);
      chk($sformatf("tbl%0d_we", r), o_ram_we, tbl[r].ce);
      if (tbl[r].ce) begin
        chk($sformatf("tbl%0d_addr", r), o_ram_addr, tbl[r].addr);
        chk($sformatf("tbl%0d_din", r), o_ram_din, tbl[r].din);
      end
      chk($sformatf("tbl%0d_done", r), o_done, tbl[r].done);
      chk($sformatf("tbl%0d_taddr", r), o_trig_addr, tbl[r].taddr);
      chk($sformatf("tbl%0d_vcnt", r), o_valid_cnt, tbl[r].vc);
      chk($sformatf("tbl%0d_saddr", r), o_start_addr, tbl[r].saddr);
    end
    for (int i = 0; i < D; i++) chk($sformatf("tbl_ram%0d", i), dut_ram[i], i + 1);
    check_ram("tbl");

    // Wrap-around; arm out of DONE restarts with an empty ring
    step(1'b1, 1'b0, '0, 1'b0);
    chk("rearm_state", o_state, 1);
    chk("rearm_vcnt", o_valid_cnt, 0);
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, DW'(k), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int k = 11; k <= 13; k++) step(1'b0, 1'b1, DW'(k), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("wrap_taddr", o_trig_addr, 2);
    chk("wrap_vcnt", o_valid_cnt, 8);
    chk("wrap_saddr", o_start_addr, 5);
    for (int i = 0; i < D; i++) chk($sformatf("wrap_ram%0d", i), dut_ram[i], exp_wrap[i]);
    check_ram("wrap");

    // Partial fill with arm and a second trigger ignored during POST
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("post_ign_state", o_state, 2);
    chk("post_ign_taddr", o_trig_addr, 2);
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b0, 1'b1, 4, 1'b1);
    chk("post_ign2_taddr", o_trig_addr, 2);
    step(1'b0, 1'b1, 5, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("part_state", o_state, 3);
    chk("part_taddr", o_trig_addr, 2);
    chk("part_vcnt", o_valid_cnt, 5);
    chk("part_saddr", o_start_addr, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("part_ram%0d", i), dut_ram[i], i + 1);
    check_ram("part");

    // Reset right after the first post sample drops its pending write
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 70, 1'b0);
    step(1'b0, 1'b1, 71, 1'b0);
    step(1'b0, 1'b1, 77, 1'b1);
    do_reset("rst_post");
    chk("rst_post_dropped", dut_ram[2], 3);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 42, 1'b0);
    chk("rst_post_addr0", o_ram_addr, 0);
    check_ram("rst_post");

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60, $urandom,
             $urandom_range(0, 99) < 10);
      end
    end
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check_ram("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
